// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register in front of the ALU.
//            - Registers the decoded operands and controls, or a NOP bubble.
//            - Forwards EX/MEM and MEM/WB results onto Op1/Op2/Store_Data.
//            - Detects hazards and holds IF/ID through Stall.
//            - Keeps a saturating count of stall bubbles.
// Config   : ID_EX_FORWARDING_EN
//              defined   - forwarding on; only load-use hazards stall.
//              undefined - no forwarding; any dependency on the EX
//                          instruction or on EX/MEM stalls.
// Ports    : clk, rst (synchronous, active high)
//            RD1/RD2/Imm, Rs/Rt/Rd, S_Op_In, decode controls, Valid_In
//            Flush (taken branch squashes the ID instruction)
//            EXMEM_* / MEMWB_* forwarding sources
//            Op1/Op2/Store_Data/S_Op/Wr_Reg/RegWrite/MemRead/MemWrite/Valid
//            Stall (combinational), Stall_Cnt (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      RD1,
    input  logic [31:0]      RD2,
    input  logic [31:0]      Imm,
    input  logic [4:0]       Rs,
    input  logic [4:0]       Rt,
    input  logic [4:0]       Rd,
    input  logic [3:0]       S_Op_In,
    input  logic             ALUSrc,
    input  logic             RegDst,
    input  logic             RegWrite_In,
    input  logic             MemRead_In,
    input  logic             MemWrite_In,
    input  logic             Valid_In,
    input  logic             Flush,
    input  logic             EXMEM_RegWrite,
    input  logic [4:0]       EXMEM_Rd,
    input  logic [31:0]      EXMEM_R,
    input  logic             MEMWB_RegWrite,
    input  logic [4:0]       MEMWB_Rd,
    input  logic [31:0]      MEMWB_Data,
    output logic [31:0]      Op1,
    output logic [31:0]      Op2,
    output logic [3:0]       S_Op,
    output logic [31:0]      Store_Data,
    output logic [4:0]       Wr_Reg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Valid,
    output logic             Stall,
    output logic [CNT_W-1:0] Stall_Cnt
);

    localparam logic [3:0] C_SOP_NOP = 4'b0111;

    logic [31:0]      r_rd1;
    logic [31:0]      r_rd2;
    logic [31:0]      r_imm;
    logic [4:0]       r_rs;
    logic [4:0]       r_rt;
    logic [4:0]       r_wr_reg;
    logic [3:0]       r_s_op;
    logic             r_alusrc;
    logic             r_regwrite;
    logic             r_memread;
    logic             r_memwrite;
    logic             r_valid;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_rt_used;
    logic             w_ex_hit;
    logic             w_hazard;
    logic             w_stall;
    logic [31:0]      w_src1;
    logic [31:0]      w_src2;

    // A destination matches a source only when it is a real register (r0 is
    // hard-wired zero and is never a dependency).
    function automatic logic src_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    // rs is always read; rt is read by R-type ops and by stores (store data).
    assign w_rt_used = ~ALUSrc | MemWrite_In;
    assign w_ex_hit  = src_hit(r_wr_reg, Rs) | (w_rt_used & src_hit(r_wr_reg, Rt));

`ifdef ID_EX_FORWARDING_EN
    // Only a load in EX cannot be forwarded in time; one bubble lets its
    // data arrive through MEM/WB.
    assign w_hazard = r_memread & r_valid & w_ex_hit;

    // EX/MEM holds the younger result, so it has priority over MEM/WB.
    assign w_src1 = (EXMEM_RegWrite & src_hit(EXMEM_Rd, r_rs)) ? EXMEM_R    :
                    (MEMWB_RegWrite & src_hit(MEMWB_Rd, r_rs)) ? MEMWB_Data : r_rd1;
    assign w_src2 = (EXMEM_RegWrite & src_hit(EXMEM_Rd, r_rt)) ? EXMEM_R    :
                    (MEMWB_RegWrite & src_hit(MEMWB_Rd, r_rt)) ? MEMWB_Data : r_rd2;
`else
    logic w_exmem_hit;
    logic w_unused_nofwd;

    // Without forwarding the consumer waits until the producer has reached
    // MEM/WB; the write-before-read register file then supplies the value.
    assign w_exmem_hit = src_hit(EXMEM_Rd, Rs) | (w_rt_used & src_hit(EXMEM_Rd, Rt));
    assign w_hazard    = (r_regwrite & r_valid & w_ex_hit) | (EXMEM_RegWrite & w_exmem_hit);

    assign w_src1 = r_rd1;
    assign w_src2 = r_rd2;

    assign w_unused_nofwd = ^{EXMEM_R, MEMWB_RegWrite, MEMWB_Rd, MEMWB_Data, r_rs, r_rt};
`endif

    // A taken branch squashes the ID instruction, so it must not also stall.
    assign w_stall = Valid_In & w_hazard & ~Flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd1       <= 32'd0;
            r_rd2       <= 32'd0;
            r_imm       <= 32'd0;
            r_rs        <= 5'd0;
            r_rt        <= 5'd0;
            r_wr_reg    <= 5'd0;
            r_s_op      <= C_SOP_NOP;
            r_alusrc    <= 1'b0;
            r_regwrite  <= 1'b0;
            r_memread   <= 1'b0;
            r_memwrite  <= 1'b0;
            r_valid     <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall || Flush) begin
                r_rd1      <= 32'd0;
                r_rd2      <= 32'd0;
                r_imm      <= 32'd0;
                r_rs       <= 5'd0;
                r_rt       <= 5'd0;
                r_wr_reg   <= 5'd0;
                r_s_op     <= C_SOP_NOP;
                r_alusrc   <= 1'b0;
                r_regwrite <= 1'b0;
                r_memread  <= 1'b0;
                r_memwrite <= 1'b0;
                r_valid    <= 1'b0;
            end else begin
                r_rd1      <= RD1;
                r_rd2      <= RD2;
                r_imm      <= Imm;
                r_rs       <= Rs;
                r_rt       <= Rt;
                r_wr_reg   <= RegDst ? Rd : Rt;
                r_s_op     <= S_Op_In;
                r_alusrc   <= ALUSrc;
                r_regwrite <= RegWrite_In;
                r_memread  <= MemRead_In;
                r_memwrite <= MemWrite_In;
                r_valid    <= Valid_In;
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign Op1        = w_src1;
    assign Op2        = r_alusrc ? r_imm : w_src2;
    assign Store_Data = w_src2;
    assign S_Op       = r_s_op;
    assign Wr_Reg     = r_wr_reg;
    assign RegWrite   = r_regwrite;
    assign MemRead    = r_memread;
    assign MemWrite   = r_memwrite;
    assign Valid      = r_valid;
    assign Stall      = w_stall;
    assign Stall_Cnt  = r_stall_cnt;

endmodule
`default_nettype wire
